// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared decode constants and ALU operation encoding
// Purpose: opcode, funct3 and funct7 constants for the supported RV32I subset,
//          the ALU operation enum and the NOP instruction word.
// Ports:   none (package)
package decode_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;  // selects SUB / SRA

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8
  } alu_op_t;

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 32-entry register file with two bypassed read ports
// Purpose: integer register file; x0 reads as zero and ignores writes.
//          Reads are combinational and forward a same-cycle write.
// Ports:   clk, reset (async, active-high)
//          i_we, i_waddr, i_wdata     write port (commits at posedge)
//          i_raddr1/o_rdata1          read port 1
//          i_raddr2/o_rdata2          read port 2
module regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_raddr1,
  output logic [XLEN-1:0] o_rdata1,
  input  logic [4:0]      i_raddr2,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] r_mem [32];
  logic            w_wr_live;

  assign w_wr_live = i_we && (i_waddr != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_live) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Forwarding lets a consumer in decode see the value being written back
  // this cycle without waiting for the array to update.
  assign o_rdata1 = (i_raddr1 == 5'd0)                   ? '0      :
                    (w_wr_live && i_waddr == i_raddr1)   ? i_wdata :
                                                           r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0)                   ? '0      :
                    (w_wr_live && i_waddr == i_raddr2)   ? i_wdata :
                                                           r_mem[i_raddr2];

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I subset decode stage with IF/ID register and regfile
// Purpose: registers fetch output in IF/ID (flush > stall > load), decodes
//          R/I-ALU/lw/sw/beq into controls and immediate, reads operands.
// Ports:   clk, reset (async, active-high)
//          if_valid/if_inst/if_pc      fetch word
//          stall, flush                IF/ID hold / invalidate
//          wb_en/wb_rd/wb_data         register write-back
//          id_valid, id_pc, rs1/rs2/rd, rs1_data/rs2_data, imm
//          alu_op, alu_src, mem_read, mem_write, reg_write, mem_to_reg,
//          branch, illegal             decoded controls (gated by id_valid)
module decode_stage #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INST = decode_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_inst,
  input  logic [31:0]     if_pc,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_valid,
  output logic [31:0]     id_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_op,
  output logic            alu_src,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic            mem_to_reg,
  output logic            branch,
  output logic            illegal
);

  import decode_pkg::*;

  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pc;

  // Flush keeps the PC so the slot still carries a meaningful address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
      r_pc    <= 32'd0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
    end else if (!stall) begin
      r_valid <= if_valid;
      r_inst  <= if_inst;
      r_pc    <= if_pc;
    end
  end

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;

  assign w_opcode = r_inst[6:0];
  assign w_funct3 = r_inst[14:12];
  assign w_funct7 = r_inst[31:25];

  alu_op_t w_alu_op;
  logic    w_alu_src;
  logic    w_mem_read;
  logic    w_mem_write;
  logic    w_reg_write;
  logic    w_mem_to_reg;
  logic    w_branch;
  logic    w_illegal;

  always_comb begin
    w_alu_op     = ALU_ADD;
    w_alu_src    = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_branch     = 1'b0;
    w_illegal    = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        w_reg_write = 1'b1;
        case (w_funct3)
          F3_ADD_SUB: w_alu_op = w_funct7[5] ? ALU_SUB : ALU_ADD;
          F3_SLL:     w_alu_op = ALU_SLL;
          F3_SLT:     w_alu_op = ALU_SLT;
          F3_XOR:     w_alu_op = ALU_XOR;
          F3_SRL_SRA: w_alu_op = w_funct7[5] ? ALU_SRA : ALU_SRL;
          F3_OR:      w_alu_op = ALU_OR;
          F3_AND:     w_alu_op = ALU_AND;
          default:    w_illegal = 1'b1;  // sltu not supported
        endcase
        // The alternate funct7 is only meaningful for sub and sra.
        if (!(w_funct7 == F7_BASE ||
              (w_funct7 == F7_ALT &&
               (w_funct3 == F3_ADD_SUB || w_funct3 == F3_SRL_SRA)))) begin
          w_illegal = 1'b1;
        end
      end
      OP_IALU: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        case (w_funct3)
          F3_ADD_SUB: w_alu_op = ALU_ADD;
          F3_SLL: begin
            w_alu_op = ALU_SLL;
            if (w_funct7 != F7_BASE) w_illegal = 1'b1;
          end
          F3_SLT:     w_alu_op = ALU_SLT;
          F3_XOR:     w_alu_op = ALU_XOR;
          F3_SRL_SRA: begin
            if (w_funct7 == F7_BASE)     w_alu_op = ALU_SRL;
            else if (w_funct7 == F7_ALT) w_alu_op = ALU_SRA;
            else                         w_illegal = 1'b1;
          end
          F3_OR:      w_alu_op = ALU_OR;
          F3_AND:     w_alu_op = ALU_AND;
          default:    w_illegal = 1'b1;  // sltiu not supported
        endcase
      end
      OP_LOAD: begin
        if (w_funct3 == F3_LW) begin
          w_reg_write  = 1'b1;
          w_alu_src    = 1'b1;
          w_mem_read   = 1'b1;
          w_mem_to_reg = 1'b1;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OP_STORE: begin
        if (w_funct3 == F3_SW) begin
          w_alu_src   = 1'b1;
          w_mem_write = 1'b1;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (w_funct3 == F3_BEQ) begin
          w_branch = 1'b1;
          w_alu_op = ALU_SUB;
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase
    // An unsupported encoding must not leave any partial control asserted.
    if (w_illegal) begin
      w_alu_op     = ALU_ADD;
      w_alu_src    = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_reg_write  = 1'b0;
      w_mem_to_reg = 1'b0;
      w_branch     = 1'b0;
    end
  end

  // Immediate format follows the opcode alone.
  logic [XLEN-1:0] w_imm;

  always_comb begin
    w_imm = '0;
    case (w_opcode)
      OP_IALU, OP_LOAD:
        w_imm = {{(XLEN-12){r_inst[31]}}, r_inst[31:20]};
      OP_STORE:
        w_imm = {{(XLEN-12){r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
      OP_BRANCH:
        w_imm = {{(XLEN-13){r_inst[31]}}, r_inst[31], r_inst[7],
                 r_inst[30:25], r_inst[11:8], 1'b0};
      default: w_imm = '0;
    endcase
  end

  regfile #(.XLEN(XLEN)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .i_we     (wb_en),
    .i_waddr  (wb_rd),
    .i_wdata  (wb_data),
    .i_raddr1 (r_inst[19:15]),
    .o_rdata1 (rs1_data),
    .i_raddr2 (r_inst[24:20]),
    .o_rdata2 (rs2_data)
  );

  assign id_valid   = r_valid;
  assign id_pc      = r_pc;
  assign rs1        = r_inst[19:15];
  assign rs2        = r_inst[24:20];
  assign rd         = r_inst[11:7];
  assign imm        = w_imm;
  assign alu_op     = r_valid ? w_alu_op : ALU_ADD;
  assign alu_src    = r_valid & w_alu_src;
  assign mem_read   = r_valid & w_mem_read;
  assign mem_write  = r_valid & w_mem_write;
  assign reg_write  = r_valid & w_reg_write;
  assign mem_to_reg = r_valid & w_mem_to_reg;
  assign branch     = r_valid & w_branch;
  assign illegal    = r_valid & w_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, if_valid, stall, flush, wb_en;
  logic [31:0] if_inst, if_pc, wb_data;
  logic [4:0]  wb_rd;

  logic        id_valid, alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, illegal;
  logic [31:0] id_pc, rs1_data, rs2_data, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_op;

  decode_stage #(.XLEN(32), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .alu_op(alu_op),
    .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .branch(branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        exp_valid;
  logic [31:0] exp_inst, exp_pc;
  logic [31:0] ref_regs [32];

  typedef struct packed {
    logic        ill;
    logic [3:0]  op;
    logic        src, mr, mw, rw, m2r, br;
    logic [31:0] imm;
  } dec_t;

  // Mnemonic-level reference: funct3 lookup table, -1 marks unsupported.
  function automatic dec_t model_decode(input logic [31:0] inst);
    dec_t        d;
    int          f3, f7, sel;
    int          alu_tab [8] = '{0, 6, 5, -1, 4, 7, 3, 2};
    logic [31:0] sx, hi, keep;
    d  = '0;
    f3 = int'(inst[14:12]);
    f7 = int'(inst[31:25]);
    sx = $signed(inst) >>> 20;
    hi = $signed(inst) >>> 31;
    sel = -1;
    case (inst[6:0])
      7'h33: begin
        sel = alu_tab[f3];
        if (f7 == 32) sel = (f3 == 0) ? 1 : (f3 == 5) ? 8 : -1;
        else if (f7 != 0) sel = -1;
        d.rw = 1;
      end
      7'h13: begin
        sel = alu_tab[f3];
        if (f3 == 1 && f7 != 0) sel = -1;
        if (f3 == 5) sel = (f7 == 0) ? 7 : (f7 == 32) ? 8 : -1;
        d.rw = 1; d.src = 1; d.imm = sx;
      end
      7'h03: begin
        sel = (f3 == 2) ? 0 : -1;
        d.rw = 1; d.src = 1; d.mr = 1; d.m2r = 1; d.imm = sx;
      end
      7'h23: begin
        sel = (f3 == 2) ? 0 : -1;
        d.src = 1; d.mw = 1; d.imm = {sx[31:5], inst[11:7]};
      end
      7'h63: begin
        sel = (f3 == 0) ? 1 : -1;
        d.br = 1;
        d.imm = (hi << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
      end
      default: sel = -1;
    endcase
    if (sel < 0) begin
      keep  = d.imm;
      d     = '0;
      d.ill = 1;
      d.imm = keep;
    end else begin
      d.op = 4'(sel);
    end
    return d;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en && wb_rd == a) return wb_data;
    return ref_regs[a];
  endfunction

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_inst  = NOP;
    exp_pc    = 32'd0;
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    dec_t d;
    d = model_decode(exp_inst);
    if (!exp_valid) begin
      d.ill = 0; d.op = 0; d.src = 0; d.mr = 0; d.mw = 0; d.rw = 0; d.m2r = 0; d.br = 0;
    end
    chk({tag, ".id_valid"},   32'(id_valid),   32'(exp_valid));
    chk({tag, ".id_pc"},      id_pc,           exp_pc);
    chk({tag, ".rs1"},        32'(rs1),        32'(exp_inst[19:15]));
    chk({tag, ".rs2"},        32'(rs2),        32'(exp_inst[24:20]));
    chk({tag, ".rd"},         32'(rd),         32'(exp_inst[11:7]));
    chk({tag, ".rs1_data"},   rs1_data,        exp_rdata(exp_inst[19:15]));
    chk({tag, ".rs2_data"},   rs2_data,        exp_rdata(exp_inst[24:20]));
    chk({tag, ".imm"},        imm,             d.imm);
    chk({tag, ".alu_op"},     32'(alu_op),     32'(d.op));
    chk({tag, ".alu_src"},    32'(alu_src),    32'(d.src));
    chk({tag, ".mem_read"},   32'(mem_read),   32'(d.mr));
    chk({tag, ".mem_write"},  32'(mem_write),  32'(d.mw));
    chk({tag, ".reg_write"},  32'(reg_write),  32'(d.rw));
    chk({tag, ".mem_to_reg"}, 32'(mem_to_reg), 32'(d.m2r));
    chk({tag, ".branch"},     32'(branch),     32'(d.br));
    chk({tag, ".illegal"},    32'(illegal),    32'(d.ill));
  endtask

  // Advance the model by the rules applied at the coming edge, then cross it.
  task automatic tick();
    if (reset) begin
      model_reset();
    end else begin
      if (flush) begin
        exp_valid = 1'b0;
        exp_inst  = NOP;
      end else if (!stall) begin
        exp_valid = if_valid;
        exp_inst  = if_inst;
        exp_pc    = if_pc;
      end
      if (wb_en && wb_rd != 5'd0) ref_regs[wb_rd] = wb_data;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] ri;
    ri = $urandom;
    case ($urandom_range(0, 5))
      0: ri[6:0] = 7'h33;
      1: ri[6:0] = 7'h13;
      2: ri[6:0] = 7'h03;
      3: ri[6:0] = 7'h23;
      4: ri[6:0] = 7'h63;
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1) ri[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 3) != 0) begin
      if (ri[6:0] == 7'h03 || ri[6:0] == 7'h23) ri[14:12] = 3'd2;
      if (ri[6:0] == 7'h63) ri[14:12] = 3'd0;
    end
    return ri;
  endfunction

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_inst = 32'd0; if_pc = 32'd0;
    stall = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    model_reset();
    tick();
    tick();
    check_all("reset");
    chk("reset.inst_is_nop_imm", imm, 32'd0);

    reset = 1'b0;
    // lw x6,-4(x9) with x9 written the same edge
    if_valid = 1'b1; if_inst = 32'hffc4a303; if_pc = 32'h40;
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h100;
    tick();
    wb_en = 1'b0;
    chk("lw.rs1", 32'(rs1), 32'd9);
    chk("lw.rd", 32'(rd), 32'd6);
    chk("lw.imm", imm, 32'hFFFFFFFC);
    chk("lw.rs1_data", rs1_data, 32'h100);
    chk("lw.ctrl", {mem_read, reg_write, mem_to_reg, alu_src, mem_write, branch}, 32'b111100);
    chk("lw.alu_op", 32'(alu_op), 32'd0);
    check_all("lw");

    // sw x6,8(x9)
    if_inst = 32'h0064a423; if_pc = 32'h44;
    tick();
    chk("sw.rs2", 32'(rs2), 32'd6);
    chk("sw.imm", imm, 32'd8);
    chk("sw.mem_write", 32'(mem_write), 32'd1);
    chk("sw.reg_write", 32'(reg_write), 32'd0);
    check_all("sw");

    // or x4,x5,x6 with x5 forwarded from write-back
    if_inst = 32'h0062e233; if_pc = 32'h48;
    tick();
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hA5;
    #1;
    chk("or.bypass", rs1_data, 32'hA5);
    chk("or.alu_op", 32'(alu_op), 32'd3);
    chk("or.reg_write", 32'(reg_write), 32'd1);
    check_all("or");

    // beq x4,x4,-12
    if_inst = 32'hfe420ae3; if_pc = 32'h4c;
    tick();
    wb_en = 1'b0;
    chk("beq.rs1", 32'(rs1), 32'd4);
    chk("beq.rs2", 32'(rs2), 32'd4);
    chk("beq.imm", imm, 32'hFFFFFFF4);
    chk("beq.branch", 32'(branch), 32'd1);
    chk("beq.alu_op", 32'(alu_op), 32'd1);
    check_all("beq");

    // two stalled cycles while fetch keeps changing
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if_inst = rand_inst(); if_pc = $urandom;
      tick();
      chk("stall.id_pc", id_pc, 32'h4c);
      chk("stall.imm", imm, 32'hFFFFFFF4);
      chk("stall.branch", 32'(branch), 32'd1);
      check_all("stall");
    end
    flush = 1'b1;
    tick();
    chk("flush.id_valid", 32'(id_valid), 32'd0);
    chk("flush.ctrl", {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, illegal}, 32'd0);
    chk("flush.id_pc", id_pc, 32'h4c);
    check_all("flush");
    stall = 1'b0; flush = 1'b0;

    // x0 is hardwired: no bypass, no write
    if_inst = 32'h000003b3; if_pc = 32'h50;
    tick();
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    #1;
    chk("x0.bypass", rs1_data, 32'd0);
    tick();
    wb_en = 1'b0;
    chk("x0.read", rs1_data, 32'd0);
    check_all("x0");

    // unsupported opcode
    if_inst = 32'h0000007f; if_pc = 32'h54;
    tick();
    chk("illegal.flag", 32'(illegal), 32'd1);
    chk("illegal.ctrl", {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch}, 32'd0);
    check_all("illegal");

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      if_valid = ($urandom_range(0, 7) != 0);
      if_inst  = rand_inst();
      if_pc    = $urandom & 32'hFFFF_FFFC;
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      wb_en    = ($urandom_range(0, 1) == 1);
      wb_rd    = 5'($urandom_range(0, 31));
      wb_data  = $urandom;
      #1;
      check_all("rand");
      tick();
    end
    stall = 1'b0; flush = 1'b0;

    // asynchronous reset mid-cycle
    if_valid = 1'b1; if_inst = 32'hffc4a303; if_pc = 32'h80;
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h100;
    tick();
    wb_en = 1'b0;
    chk("pre_reset.rs1_data", rs1_data, 32'h100);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_reset.id_valid", 32'(id_valid), 32'd0);
    chk("async_reset.mem_read", 32'(mem_read), 32'd0);
    check_all("async_reset");
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset.rs1", 32'(rs1), 32'd9);
    chk("post_reset.rs1_data", rs1_data, 32'd0);
    check_all("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
